// File: rtl/doodle_pkg.sv
// Shared types, default screen geometry and arithmetic helpers for the doodle physics engine.
package doodle_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DEAD = 2'd2
  } game_state_e;

  typedef enum logic [2:0] {
    WAIT    = 3'd0,
    UPDATE  = 3'd1,
    SCAN    = 3'd2,
    RESOLVE = 3'd3,
    SCROLL  = 3'd4
  } frame_phase_e;

  localparam int DEF_SCREEN_X_MAX = 639;
  localparam int DEF_SCREEN_Y_MAX = 479;
  localparam int DEF_WRAP_MARGIN  = 25;
  localparam int DEF_SCROLL_LINE  = 240;

  // Signed add clamped to [lo, hi].
  function automatic int sat_add(input int a, input int b, input int lo, input int hi);
    int s;
    s = a + b;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/plat_collision_scan.sv
// Sequential platform collision scanner: tests one platform slot per enabled cycle and
// latches the lowest-index hit.
module plat_collision_scan
  import doodle_pkg::*;
#(
  parameter int NUM_PLAT    = 16,
  parameter int COORD_W     = 10,
  parameter int DOODLE_SIZE = 6
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          clear,
  input  logic                          en,
  input  logic [COORD_W-1:0]            x,
  input  logic [COORD_W-1:0]            y,
  input  logic                          vel_nonneg,
  input  logic [NUM_PLAT*COORD_W-1:0]   plat_x,
  input  logic [NUM_PLAT*COORD_W-1:0]   plat_y,
  input  logic [NUM_PLAT-1:0]           plat_valid,
  input  logic [COORD_W-1:0]            half_w,
  input  logic [COORD_W-1:0]            half_h,
  output logic                          hit,
  output logic [$clog2(NUM_PLAT)-1:0]   hit_idx,
  output logic                          done
);

  localparam int IDX_W = $clog2(NUM_PLAT);
  localparam int CMP_W = COORD_W + 2;

  logic [IDX_W-1:0]   idx;
  logic [COORD_W-1:0] px, py;
  logic [CMP_W-1:0]   xe, pxe, pye, hhe, feet, reach;
  logic               cand;

  // Two guard bits keep every sum below from wrapping.
  always_comb begin
    px    = plat_x[int'(idx)*COORD_W +: COORD_W];
    py    = plat_y[int'(idx)*COORD_W +: COORD_W];
    xe    = CMP_W'(x);
    pxe   = CMP_W'(px);
    pye   = CMP_W'(py);
    hhe   = CMP_W'(half_h);
    feet  = CMP_W'(y) + CMP_W'(DOODLE_SIZE);
    reach = CMP_W'(half_w) + CMP_W'(DOODLE_SIZE);
    cand  = plat_valid[idx] && vel_nonneg &&
            (feet + hhe >= pye) && (feet <= pye + hhe) &&
            (xe + reach >= pxe) && (pxe + reach >= xe);
    done  = en && (idx == IDX_W'(NUM_PLAT - 1));
  end

  always_ff @(posedge Clk) begin
    if (Reset || clear) begin
      idx     <= '0;
      hit     <= 1'b0;
      hit_idx <= '0;
    end else if (en) begin
      if (cand && !hit) begin
        hit     <= 1'b1;
        hit_idx <= idx;
      end
      idx <= done ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/doodle_physics_engine.sv
// Doodle jump physics: per-frame multi-cycle job (update, platform scan, bounce/fall resolve,
// camera scroll) wrapped in an IDLE/PLAY/DEAD game state machine.
module doodle_physics_engine
  import doodle_pkg::*;
#(
  parameter int NUM_PLAT     = 16,
  parameter int COORD_W      = 10,
  parameter int VEL_W        = 8,
  parameter int GRAVITY      = 1,
  parameter int GRAV_DIV     = 4,
  parameter int JUMP_VEL     = 12,
  parameter int MAX_FALL     = 10,
  parameter int X_SPEED      = 3,
  parameter int DOODLE_SIZE  = 6,
  parameter int SCREEN_X_MAX = DEF_SCREEN_X_MAX,
  parameter int SCREEN_Y_MAX = DEF_SCREEN_Y_MAX,
  parameter int WRAP_MARGIN  = DEF_WRAP_MARGIN,
  parameter int SCROLL_LINE  = DEF_SCROLL_LINE
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          frame_tick,
  input  logic                          start,
  input  logic                          pause,
  input  logic                          move_left,
  input  logic                          move_right,
  input  logic [NUM_PLAT*COORD_W-1:0]   plat_x,
  input  logic [NUM_PLAT*COORD_W-1:0]   plat_y,
  input  logic [NUM_PLAT-1:0]           plat_valid,
  input  logic [COORD_W-1:0]            plat_half_w,
  input  logic [COORD_W-1:0]            plat_half_h,
  output logic [COORD_W-1:0]            doodle_x,
  output logic [COORD_W-1:0]            doodle_y,
  output logic signed [VEL_W-1:0]       vel_y,
  output logic [COORD_W-1:0]            scroll_dy,
  output logic                          scroll_valid,
  output logic                          landed,
  output logic [$clog2(NUM_PLAT)-1:0]   land_idx,
  output logic                          fell,
  output logic                          busy,
  output logic                          overrun,
  output logic [1:0]                    game_state
);

  localparam int IDX_W   = $clog2(NUM_PLAT);
  localparam int GC_W    = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
  localparam int X_START = (SCREEN_X_MAX + 1) / 2;
  localparam int VEL_MIN = -(2 ** (VEL_W - 1));

  game_state_e  state;
  frame_phase_e phase;
  logic [GC_W-1:0] grav_cnt, grav_next;

  logic signed [VEL_W-1:0] vel_next;
  logic signed [COORD_W:0] dx, x_sum, y_sum;
  logic [COORD_W-1:0]      x_next, y_next;
  int                      x_sum_i;

  logic             scan_hit, scan_done;
  logic [IDX_W-1:0] scan_idx;

  assign game_state = state;

  always_comb begin
    grav_next = grav_cnt + 1'b1;
    vel_next  = vel_y;
    if (int'(grav_cnt) == GRAV_DIV - 1) begin
      grav_next = '0;
      vel_next  = VEL_W'(sat_add(int'(vel_y), GRAVITY, VEL_MIN, MAX_FALL));
    end

    dx = '0;
    if (move_right && !move_left) dx = (COORD_W+1)'(X_SPEED);
    else if (move_left && !move_right) dx = (COORD_W+1)'(-X_SPEED);

    x_sum   = $signed({1'b0, doodle_x}) + dx;
    x_sum_i = int'(x_sum);
    if (x_sum_i < WRAP_MARGIN) x_next = COORD_W'(SCREEN_X_MAX - WRAP_MARGIN - 1);
    else if (x_sum_i > SCREEN_X_MAX - WRAP_MARGIN) x_next = COORD_W'(WRAP_MARGIN);
    else x_next = x_sum[COORD_W-1:0];

    // Position integrates the already-updated velocity; negative results clamp to the top row.
    y_sum  = $signed({1'b0, doodle_y}) + (COORD_W+1)'(vel_next);
    y_next = y_sum[COORD_W] ? '0 : y_sum[COORD_W-1:0];
  end

  plat_collision_scan #(
    .NUM_PLAT   (NUM_PLAT),
    .COORD_W    (COORD_W),
    .DOODLE_SIZE(DOODLE_SIZE)
  ) u_scan (
    .Clk       (Clk),
    .Reset     (Reset),
    .clear     (phase == UPDATE),
    .en        (phase == SCAN),
    .x         (doodle_x),
    .y         (doodle_y),
    .vel_nonneg(~vel_y[VEL_W-1]),
    .plat_x    (plat_x),
    .plat_y    (plat_y),
    .plat_valid(plat_valid),
    .half_w    (plat_half_w),
    .half_h    (plat_half_h),
    .hit       (scan_hit),
    .hit_idx   (scan_idx),
    .done      (scan_done)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      phase        <= WAIT;
      grav_cnt     <= '0;
      doodle_x     <= COORD_W'(X_START);
      doodle_y     <= COORD_W'(SCROLL_LINE);
      vel_y        <= '0;
      scroll_dy    <= '0;
      scroll_valid <= 1'b0;
      landed       <= 1'b0;
      land_idx     <= '0;
      fell         <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      scroll_valid <= 1'b0;
      landed       <= 1'b0;
      fell         <= 1'b0;
      if (start && state != PLAY) begin
        state    <= PLAY;
        phase    <= WAIT;
        busy     <= 1'b0;
        overrun  <= 1'b0;
        grav_cnt <= '0;
        doodle_x <= COORD_W'(X_START);
        doodle_y <= COORD_W'(SCROLL_LINE);
        vel_y    <= VEL_W'(-JUMP_VEL);
      end else begin
        if (frame_tick && !pause && state == PLAY) begin
          if (busy) begin
            overrun <= 1'b1;
          end else begin
            phase <= UPDATE;
            busy  <= 1'b1;
          end
        end
        unique case (phase)
          WAIT: ;
          UPDATE: begin
            grav_cnt <= grav_next;
            vel_y    <= vel_next;
            doodle_x <= x_next;
            doodle_y <= y_next;
            phase    <= SCAN;
          end
          SCAN: if (scan_done) phase <= RESOLVE;
          RESOLVE: begin
            if (scan_hit) begin
              vel_y    <= VEL_W'(-JUMP_VEL);
              landed   <= 1'b1;
              land_idx <= scan_idx;
            end else if (int'(doodle_y) + DOODLE_SIZE >= SCREEN_Y_MAX) begin
              fell  <= 1'b1;
              state <= DEAD;
            end
            phase <= SCROLL;
          end
          SCROLL: begin
            if (int'(doodle_y) < SCROLL_LINE) begin
              scroll_dy    <= COORD_W'(SCROLL_LINE - int'(doodle_y));
              doodle_y     <= COORD_W'(SCROLL_LINE);
              scroll_valid <= 1'b1;
            end
            phase <= WAIT;
            busy  <= 1'b0;
          end
          default: phase <= WAIT;
        endcase
      end
    end
  end

endmodule

// File: doc/doodle_physics_engine.md
Name: doodle_physics_engine

Overview:
- Parametrised successor of the doodle jump/physics block. Handles N platforms, configurable gravity, jump impulse and screen geometry, horizontal wrap, camera scroll and game-over detection.
- Runs on the system clock. Each frame is processed as a multi-cycle job triggered by a frame_tick strobe.
- Platform collision is scanned sequentially, one platform per cycle, by a sub-module.
- Sits between the keyboard/jump-state control and the platform generator / sprite renderer.

Parameters:
- NUM_PLAT, 16, number of platform slots scanned per frame
- COORD_W, 10, coordinate width, unsigned
- VEL_W, 8, vertical velocity width, two's complement
- GRAVITY, 1, velocity increment per gravity step
- GRAV_DIV, 4, frames per gravity step
- JUMP_VEL, 12, magnitude of the upward impulse
- MAX_FALL, 10, positive velocity saturation limit
- X_SPEED, 3, horizontal step per frame
- DOODLE_SIZE, 6, doodle half-size
- SCREEN_X_MAX, 639, last pixel column
- SCREEN_Y_MAX, 479, last pixel row
- WRAP_MARGIN, 25, horizontal wrap guard band
- SCROLL_LINE, 240, doodle y above which the camera scrolls

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high
- frame_tick  in  1  one-cycle strobe per video frame
- start  in  1  launch game from IDLE or DEAD
- pause  in  1  level; frame_tick ignored while high
- move_left  in  1  level, from keycode decode
- move_right  in  1  level, from keycode decode
- plat_x  in  NUM_PLAT*COORD_W  packed platform centres X; slot i at [i*COORD_W +: COORD_W]
- plat_y  in  NUM_PLAT*COORD_W  packed platform centres Y, same packing
- plat_valid  in  NUM_PLAT  slot occupied
- plat_half_w  in  COORD_W  platform half-width
- plat_half_h  in  COORD_W  platform half-height
- doodle_x  out  COORD_W  doodle X position
- doodle_y  out  COORD_W  doodle Y position
- vel_y  out  VEL_W  signed vertical velocity
- scroll_dy  out  COORD_W  camera scroll amount, valid with scroll_valid
- scroll_valid  out  1  one-cycle pulse
- landed  out  1  one-cycle pulse on platform bounce
- land_idx  out  $clog2(NUM_PLAT)  index of the platform landed on
- fell  out  1  one-cycle pulse on game over
- busy  out  1  frame job in progress
- overrun  out  1  sticky: a frame_tick arrived while busy
- game_state  out  2  encoded FSM macro state

Behaviour:
- Reset (synchronous) values:
  - doodle_x=320, doodle_y=SCROLL_LINE, vel_y=0
  - scroll_dy=0, land_idx=0
  - all pulses 0, busy=0, overrun=0
  - grav_cnt=0, game_state=IDLE
- Reset asserted during any state aborts the job and takes effect the next cycle.
- Macro states are IDLE, PLAY and DEAD.
  - start in IDLE or DEAD: x=320, y=SCROLL_LINE, vel_y=-JUMP_VEL, grav_cnt=0, go to PLAY.
- Frame job, started by frame_tick in PLAY with pause=0 and busy=0:
  - UPDATE (1 cycle):
    - grav_cnt increments, wrapping at GRAV_DIV-1.
    - On wrap, vel_y += GRAVITY, saturating at MAX_FALL.
    - dx = +X_SPEED if only move_right, -X_SPEED if only move_left, otherwise 0.
    - x += dx, computed in COORD_W+1 signed.
    - If the new x < WRAP_MARGIN, x = SCREEN_X_MAX-WRAP_MARGIN-1. If new x > SCREEN_X_MAX-WRAP_MARGIN, x = WRAP_MARGIN.
    - y += vel_y, computed in COORD_W+1 signed, clamped at 0.
  - SCAN (NUM_PLAT cycles):
    - Platform i is tested on cycle i.
    - Hit condition: plat_valid[i], vel_y ≥ 0, and feet = y+DOODLE_SIZE satisfies feet+half_h ≥ py and feet ≤ py+half_h.
    - Also |x-px| ≤ half_w+DOODLE_SIZE.
    - All comparisons use COORD_W+2 unsigned widths, so none underflow.
    - The first (lowest-index) hit is latched; later hits are ignored.
  - RESOLVE (1 cycle), checked in this priority order:
    - Hit: vel_y = -JUMP_VEL, landed=1, land_idx=i.
    - Otherwise, if y+DOODLE_SIZE ≥ SCREEN_Y_MAX: fell=1, go to DEAD.
  - SCROLL (1 cycle):
    - If y < SCROLL_LINE: scroll_dy = SCROLL_LINE-y, y = SCROLL_LINE, scroll_valid=1.
    - Otherwise no action.
- Total job latency is NUM_PLAT+3 cycles. busy is high from the cycle after frame_tick through SCROLL.
- A frame_tick arriving while busy is dropped and sets overrun. overrun clears only on Reset or start.
- pause freezes all state; the job in flight still completes.
- DEAD: outputs hold their last values, frame_tick is ignored, and only start leaves the state.
- Simultaneous start and frame_tick: start wins and no job runs that cycle.
- Platform inputs must be stable from frame_tick until busy falls; the platform generator applies scroll_dy after scroll_valid.

Decomposition:
- Package doodle_pkg holds:
  - the game_state_e enum (IDLE=0, PLAY=1, DEAD=2)
  - the frame_phase_e enum (WAIT, UPDATE, SCAN, RESOLVE, SCROLL)
  - the default screen constants
  - a signed saturating-add function
- Sub-module plat_collision_scan, instantiated once, contains:
  - the index counter and the one-platform comparator
  - first-hit latch
  - outputs hit, hit_idx and done

Test Plan:
- Reset, start, one frame_tick with no key pressed → y=228 after UPDATE; scroll_valid with scroll_dy=12; final y=240, vel_y=-12, busy low 19 cycles after the tick.
- Gravity, GRAV_DIV=4, no platforms, 8 ticks → vel_y steps -12 → -11 (tick 4) → -10 (tick 8).
- Wrap: x=27, move_left held, one tick → x=613. Both keys held → x unchanged.
- Overlapping platforms: valid slots 3 and 7 both satisfy the hit condition while falling → landed=1, land_idx=3, vel_y=-12.
- Fall: no valid platforms, ticks until feet ≥ 479 → fell pulse once, game_state=DEAD; further ticks change nothing; start → PLAY, x=320, y=240.
- Overrun and Reset: a second tick 2 cycles after the first → overrun=1, one job only. Reset asserted mid-SCAN → reset values the next cycle, no landed pulse.
